// File: rtl/fp32_div_pkg.sv
// Shared binary32 divider definitions: field widths, bias, special encodings, flag positions.
// No logic; consumed by the operand front-end and the export stage.
// Flag vector order is {zero_a, inf_a, nan_a, zero_b, inf_b, nan_b}.
package fp32_div_pkg;

    localparam int EXP  = 8;
    localparam int FRAC = 23;
    localparam int MANT = 24;
    localparam int BIAS = 127;

    localparam logic [EXP-1:0] EXP_MAX = 8'd255;
    localparam logic [31:0]    QNAN    = 32'h7FFF_FFFF;
    localparam logic [30:0]    INF     = 31'h7F80_0000;

    localparam int F_ZERO_A = 5;
    localparam int F_INF_A  = 4;
    localparam int F_NAN_A  = 3;
    localparam int F_ZERO_B = 2;
    localparam int F_INF_B  = 1;
    localparam int F_NAN_B  = 0;

    typedef struct packed {
        logic            sign;
        logic [EXP-1:0]  exp;
        logic [FRAC-1:0] frac;
    } fp32_t;

    // Hidden bit is dropped for zero-class operands (denormals flush to zero).
    function automatic logic [MANT-1:0] unpack_mant(input fp32_t x, input logic is_zero);
        return {~is_zero, x.frac};
    endfunction

endpackage

// File: rtl/checkspecial.sv
// Classifies the magnitude of one binary32 operand as zero, infinity or NaN.
// Latency: combinational.
// Backpressure: none; pure function of its input.
module checkspecial
    import fp32_div_pkg::*;
(
    input  logic [30:0] mag,
    output logic        flag_zero,
    output logic        flag_inf,
    output logic        flag_nan
);

    assign flag_zero = (mag[30:23] == '0);
    assign flag_inf  = (mag == INF);
    assign flag_nan  = (mag[30:23] == EXP_MAX) && (mag[22:0] != '0);

endmodule

// File: rtl/import_operand_div.sv
// Operand front-end for the binary32 divider: classify, unpack, pre-normalize, quotient exponent.
// Latency: 2 cycles accept-to-output, 1 pair/cycle, at most 2 pairs in flight.
// Backpressure: each stage loads when empty or drained; outputs hold while out_valid && !out_ready.
module import_operand_div
    import fp32_div_pkg::*;
#(
    parameter int BIAS  = fp32_div_pkg::BIAS,
    parameter int EXP_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       A,
    input  logic [31:0]       B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       a_raw,
    output logic [31:0]       b_raw,
    output logic              sign_q,
    output logic [EXP_W-1:0]  exp_q,
    output logic [24:0]       mant_a,
    output logic [23:0]       mant_b,
    output logic [5:0]        flags,
    output logic              bypass,
    output logic              ovf,
    output logic              unf
);

    logic             s2_load;
    logic             s1_acc;
    logic             zero_a, inf_a, nan_a;
    logic             zero_b, inf_b, nan_b;

    logic             s1_valid;
    logic [31:0]      s1_a, s1_b;
    logic [5:0]       s1_flags;
    logic [MANT-1:0]  s1_ma, s1_mb;
    logic [EXP_W-1:0] s1_ea, s1_eb;

    logic             byp_c;
    logic             shift_c;
    logic [EXP_W-1:0] exp_c;
    logic [24:0]      mant_a_c;
    logic             ovf_c, unf_c;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign s1_acc   = in_valid && in_ready;

    checkspecial u_check_a (.mag(A[30:0]), .flag_zero(zero_a), .flag_inf(inf_a), .flag_nan(nan_a));
    checkspecial u_check_b (.mag(B[30:0]), .flag_zero(zero_b), .flag_inf(inf_b), .flag_nan(nan_b));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_flags <= '0;
            s1_ma    <= '0;
            s1_mb    <= '0;
            s1_ea    <= '0;
            s1_eb    <= '0;
        end else begin
            if (in_ready)
                s1_valid <= in_valid;
            if (s1_acc) begin
                s1_a     <= A;
                s1_b     <= B;
                s1_flags <= {zero_a, inf_a, nan_a, zero_b, inf_b, nan_b};
                s1_ma    <= unpack_mant(fp32_t'(A), zero_a);
                s1_mb    <= unpack_mant(fp32_t'(B), zero_b);
                s1_ea    <= EXP_W'(A[30:23]);
                s1_eb    <= EXP_W'(B[30:23]);
            end
        end
    end

    // Shift the dividend left when its mantissa is smaller so the quotient lands in [1,2).
    assign byp_c    = |s1_flags;
    assign shift_c  = (s1_ma < s1_mb) && !byp_c;
    assign mant_a_c = shift_c ? {s1_ma, 1'b0} : {1'b0, s1_ma};
    assign exp_c    = s1_ea - s1_eb + EXP_W'(BIAS) - EXP_W'(shift_c);
    assign ovf_c    = !exp_c[EXP_W-1] && (exp_c >= EXP_W'(EXP_MAX));
    assign unf_c    = exp_c[EXP_W-1] || (exp_c == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            a_raw     <= '0;
            b_raw     <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mant_a    <= '0;
            mant_b    <= '0;
            flags     <= '0;
            bypass    <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                a_raw  <= s1_a;
                b_raw  <= s1_b;
                sign_q <= s1_a[31] ^ s1_b[31];
                exp_q  <= exp_c;
                mant_a <= mant_a_c;
                mant_b <= s1_mb;
                flags  <= s1_flags;
                bypass <= byp_c;
                ovf    <= ovf_c;
                unf    <= unf_c;
            end
        end
    end

endmodule
